mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage controller between the EX/MEM latch and the MEM/WB latch of the pipelined MIPS core.
- Turns a stage-resident load/store (including LL/SC) into a dcache request and holds the pipeline until dhit.
- Captures load data or the SC result for dload_i of the MEM/WB latch.
- Keeps the per-core LL/SC link register, which coherence snoops invalidate.

Parameters:
WORD_W, 32, data/address width
OFS_BITS, 2, low address bits ignored in link-address compares (word granularity)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
exmem_valid  in  1  EX/MEM holds a valid instruction
memren_i  in  1  load (lw/ll)
memwen_i  in  1  store (sw/sc)
ll_i  in  1  instruction is LL (with memren_i)
sc_i  in  1  instruction is SC (with memwen_i)
addr_i  in  WORD_W  effective address from EX/MEM
store_i  in  WORD_W  store data from EX/MEM
dhit  in  1  dcache completes current request
dmemload  in  WORD_W  dcache read data, valid with dhit
snoop_inv  in  1  coherence invalidate this cycle
snoop_addr  in  WORD_W  invalidated address
dREN  out  1  dcache read request
dWEN  out  1  dcache write request
daddr  out  WORD_W  dcache address
dstore  out  WORD_W  dcache write data
dload_o  out  WORD_W  registered load data / SC result to MEM/WB
mem_busy  out  1  stall; MEM/WB and upstream latches enable = !mem_busy

Behaviour:
- Reset (async, any state, mid-request included):
  - state=IDLE, dload_o=0, link_valid=0, link_addr=0.
  - dREN/dWEN drop immediately.
- req = exmem_valid & (memren_i | memwen_i).
  - memren_i & memwen_i together: treated as a store.
- sc_ok = link_valid & (addr_i[W-1:OFS_BITS] == link_addr[W-1:OFS_BITS]).
- FSM:
  - IDLE: mem_busy = req.
    - req & sc_i & !sc_ok -> DONE; dload_o<=0; no bus access.
    - Otherwise req -> ACCESS.
    - No req: stay.
  - ACCESS: mem_busy=1.
    - dREN = load, dWEN = store; daddr=addr_i; dstore=store_i.
    - Stay until dhit; dhit -> DONE.
    - Capture on dhit: load -> dload_o<=dmemload; SC -> dload_o<=1; plain SW -> dload_o unchanged.
  - DONE: mem_busy=0 for exactly one cycle; MEM/WB captures; -> IDLE unconditionally. No re-issue, since EX/MEM advances on the same edge.
- Outside ACCESS: dREN=dWEN=0, daddr=0, dstore=0.
- Latency (dhit k cycles after ACCESS entry, k>=0):
  - mem_busy high for k+2 cycles; DONE follows.
  - Failed SC: mem_busy high 1 cycle, then DONE.
- Inputs are held stable by the stalled EX/MEM latch while mem_busy=1.
- Link register, evaluated per edge in this priority order:
  1. LL completing (ACCESS & dhit & ll_i): link_addr<=addr_i, link_valid<=1.
  2. Then cleared (link_valid<=0) by any of:
     - SC leaving IDLE (success or fail);
     - own SW completing whose word address matches link_addr;
     - snoop_inv with snoop_addr word-matching link_addr (or addr_i when an LL completes the same cycle).
  - A snoop in the same cycle as LL completion to the same word therefore leaves link_valid=0.
- SC success is decided at IDLE issue. A snoop during the SC ACCESS does not change the result.
- exmem_valid=0 never starts a request. exmem_valid dropping during ACCESS does not abort; EX/MEM cannot change while stalled.

Test Plan:
- LW addr=0x100, dhit 3 cycles after ACCESS entry, dmemload=0xDEADBEEF -> dREN=1 for 4 cycles, daddr=0x100; mem_busy high 5 cycles; DONE cycle dload_o=0xDEADBEEF, mem_busy=0.
- SW addr=0x200 store_i=0x12345678, dhit same cycle as ACCESS entry -> dWEN=1 one cycle, dstore=0x12345678; mem_busy 2 cycles; dload_o unchanged.
- LL 0x300 (dhit) then SC 0x300 -> SC issues dWEN, dload_o=1, link_valid=0. A second SC 0x300 -> no dWEN, dload_o=0, mem_busy 1 cycle.
- LL 0x300, then snoop_inv with snoop_addr=0x302 (same word), then SC 0x300 -> SC fails: no bus access, dload_o=0.
- snoop_inv with snoop_addr=0x300 in the same cycle as LL 0x300 dhit -> link_valid=0; a following SC fails.
- nRST asserted mid-ACCESS (dREN=1) -> dREN=0 immediately, state IDLE, dload_o=0, link_valid=0. After release with req held, the access restarts from IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: dcache handshake, load/SC capture
// and the LL/SC link register with snoop invalidation.
module mem_access_unit #(
   parameter int WORD_W   = 32,
   parameter int OFS_BITS = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              exmem_valid,
   input  logic              memren_i,
   input  logic              memwen_i,
   input  logic              ll_i,
   input  logic              sc_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] store_i,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   input  logic              snoop_inv,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] daddr,
   output logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload_o,
   output logic              mem_busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state;
   logic                link_valid;
   logic [WORD_W-1:0]   link_addr;

   logic                req, is_load, is_store;
   logic                sc_req, ll_req, sc_ok;
   logic                in_idle, in_acc, acc_done, ll_done;
   logic                clr_link, nxt_valid;
   logic [WORD_W-1:0]   nxt_addr;

   function automatic logic wmatch(input logic [WORD_W-1:0] a,
                                   input logic [WORD_W-1:0] b);
      return a[WORD_W-1:OFS_BITS] == b[WORD_W-1:OFS_BITS];
   endfunction

   // load+store together resolves to a store
   assign is_store = memwen_i;
   assign is_load  = memren_i & ~memwen_i;
   assign req      = exmem_valid & (memren_i | memwen_i);
   assign sc_req   = sc_i & is_store;
   assign ll_req   = ll_i & is_load;
   assign sc_ok    = link_valid & wmatch(addr_i, link_addr);

   assign in_idle  = (state == IDLE);
   assign in_acc   = (state == ACCESS);
   assign acc_done = in_acc & dhit;
   assign ll_done  = acc_done & ll_req;

   // LL sets first; clears below see the freshly linked address
   assign nxt_addr  = ll_done ? addr_i : link_addr;
   assign nxt_valid = link_valid | ll_done;
   assign clr_link  = (in_idle & req & sc_req)
                    | (acc_done & is_store & wmatch(addr_i, nxt_addr))
                    | (snoop_inv & wmatch(snoop_addr, nxt_addr));

   assign dREN     = in_acc & is_load;
   assign dWEN     = in_acc & is_store;
   assign daddr    = in_acc ? addr_i  : '0;
   assign dstore   = in_acc ? store_i : '0;
   assign mem_busy = in_acc | (in_idle & req);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         dload_o    <= '0;
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         link_addr  <= nxt_addr;
         link_valid <= nxt_valid & ~clr_link;
         unique case (state)
            IDLE: begin
               if (req) begin
                  if (sc_req && !sc_ok) begin
                     state   <= DONE;
                     dload_o <= '0;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (dhit) begin
                  state <= DONE;
                  if (is_load)
                     dload_o <= dmemload;
                  else if (sc_req)
                     dload_o <= {{(WORD_W-1){1'b0}}, 1'b1};
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level
// model of loads, stores, LL/SC and snoops.
module tb_mem_access_unit;

   logic        CLK = 0;
   logic        nRST = 0;
   logic        exmem_valid = 0, memren_i = 0, memwen_i = 0;
   logic        ll_i = 0, sc_i = 0;
   logic [31:0] addr_i = 0, store_i = 0;
   logic        dhit = 0;
   logic [31:0] dmemload = 0;
   logic        snoop_inv = 0;
   logic [31:0] snoop_addr = 0;
   logic        dREN, dWEN, mem_busy;
   logic [31:0] daddr, dstore, dload_o;

   mem_access_unit dut (
      .CLK(CLK), .nRST(nRST),
      .exmem_valid(exmem_valid), .memren_i(memren_i),
      .memwen_i(memwen_i), .ll_i(ll_i), .sc_i(sc_i),
      .addr_i(addr_i), .store_i(store_i),
      .dhit(dhit), .dmemload(dmemload),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload_o(dload_o), .mem_busy(mem_busy)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // reference state
   bit          m_lv;
   logic [31:0] m_la;
   logic [31:0] m_dl;

   localparam int LW = 0, SW = 1, LL = 2, SC = 3;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit same_word(input logic [31:0] a,
                                    input logic [31:0] b);
      return (a >> 2) == (b >> 2);
   endfunction

   // Drive one instruction from a negedge until its DONE cycle.
   task automatic run_op(input int op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int k, input bit snp,
                         input logic [31:0] sa);
      bit fail, isld, timeout;
      int busy_n, rd_n, wr_n, acc_n;
      isld = (op == LW) || (op == LL);
      fail = (op == SC) && !(m_lv && same_word(a, m_la));
      memren_i = isld;
      memwen_i = !isld;
      ll_i = (op == LL);
      sc_i = (op == SC);
      addr_i = a;
      store_i = wd;
      dmemload = rd;
      exmem_valid = 1;
      busy_n = 0; rd_n = 0; wr_n = 0; acc_n = 0;
      timeout = 1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!mem_busy) begin
            timeout = 0;
            break;
         end
         busy_n++;
         if (dREN) rd_n++;
         if (dWEN) wr_n++;
         if (dREN || dWEN) begin
            acc_n++;
            check("daddr", daddr, a);
            if (dWEN) check("dstore", dstore, wd);
            dhit = (acc_n == k + 1);
         end else begin
            dhit = 0;
         end
         snoop_inv = dhit & snp;
         snoop_addr = sa;
         @(negedge CLK);
      end
      check("timeout", {31'b0, timeout}, 32'd0);
      dhit = 0;
      snoop_inv = 0;
      // model
      if (op == SC) m_lv = 0;
      if (!fail) begin
         if (isld) m_dl = rd;
         else if (op == SC) m_dl = 32'd1;
      end else begin
         m_dl = 32'd0;
      end
      if (op == LL) begin
         m_la = a;
         m_lv = 1;
      end
      if (op == SW && m_lv && same_word(a, m_la)) m_lv = 0;
      if (snp && !fail && m_lv && same_word(sa, m_la)) m_lv = 0;
      check("busy_cycles", busy_n, fail ? 1 : k + 2);
      check("rd_cycles", rd_n, (isld && !fail) ? k + 1 : 0);
      check("wr_cycles", wr_n, (!isld && !fail) ? k + 1 : 0);
      check("dload_o", dload_o, m_dl);
      exmem_valid = 0;
      @(negedge CLK);
      #1;
      check("idle_busy", {31'b0, mem_busy}, 32'd0);
      @(negedge CLK);
   endtask

   task automatic snoop(input logic [31:0] sa);
      snoop_inv = 1;
      snoop_addr = sa;
      @(negedge CLK);
      snoop_inv = 0;
      if (m_lv && same_word(sa, m_la)) m_lv = 0;
   endtask

   logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h300, 32'h302};

   initial begin
      m_lv = 0; m_la = 0; m_dl = 0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_dload", dload_o, 32'd0);
      check("rst_busy", {31'b0, mem_busy}, 32'd0);
      nRST = 1;
      @(negedge CLK);

      memren_i = 1;
      #1;
      check("novalid_busy", {31'b0, mem_busy}, 32'd0);
      memren_i = 0;
      @(negedge CLK);

      run_op(LW, 32'h100, 0, 32'hDEADBEEF, 3, 0, 0);
      run_op(SW, 32'h200, 32'h12345678, 32'h0, 0, 0, 0);
      run_op(LL, 32'h300, 0, 32'h55, 1, 0, 0);
      run_op(SC, 32'h300, 32'hA5A5, 0, 2, 0, 0);
      run_op(SC, 32'h300, 32'hA5A5, 0, 0, 0, 0);
      run_op(LL, 32'h300, 0, 32'h66, 0, 0, 0);
      snoop(32'h302);
      run_op(SC, 32'h300, 32'h1, 0, 0, 0, 0);
      run_op(LL, 32'h300, 0, 32'h77, 2, 1, 32'h300);
      run_op(SC, 32'h300, 32'h2, 0, 0, 0, 0);

      // reset mid-access with a live link
      run_op(LL, 32'h300, 0, 32'h88, 0, 0, 0);
      memren_i = 1; memwen_i = 0; ll_i = 0; sc_i = 0;
      addr_i = 32'h100; exmem_valid = 1;
      @(negedge CLK);
      #1;
      check("pre_rst_dREN", {31'b0, dREN}, 32'd1);
      nRST = 0;
      #1;
      check("rst_dREN", {31'b0, dREN}, 32'd0);
      check("rst_daddr", daddr, 32'd0);
      check("rst_dload2", dload_o, 32'd0);
      m_lv = 0;
      m_dl = 0;
      @(negedge CLK);
      nRST = 1;
      run_op(LW, 32'h100, 0, 32'hCAFEF00D, 1, 0, 0);
      run_op(SC, 32'h300, 32'h3, 0, 0, 0, 0);

      for (int i = 0; i < 60; i++) begin
         int op, k;
         logic [31:0] a, sa;
         op = $urandom_range(0, 3);
         k = $urandom_range(0, 4);
         a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFC)
                                          : pool[$urandom_range(0, 3)];
         sa = pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 4) == 0) snoop(sa);
         run_op(op, a, $urandom, $urandom, k,
                ($urandom_range(0, 3) == 0), sa);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
